// File: rtl/cmd_parser.sv
// Byte-stream command parser: short single-byte commands and 5-byte long
// commands (opcode + 4 data bytes), decoded into one-cycle strobe pulses.
//
// state | meaning
// IDLE  | waiting for a short command or a long-command opcode
// DATA  | collecting the 4 data bytes of a long command
module cmd_parser #(
    parameter int STAGES = 4,
    parameter int TMO    = 65536
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic [7:0]        byte_i,
    input  logic              stb_i,
    output logic [31:0]       cmd_o,
    output logic [STAGES-1:0] set_mask_o,
    output logic [STAGES-1:0] set_val_o,
    output logic [STAGES-1:0] set_cfg_o,
    output logic              arm_o,
    output logic              sw_rst_o,
    output logic              id_o,
    output logic              xon_o,
    output logic              xoff_o,
    output logic              set_div_o,
    output logic              set_cnt_o,
    output logic              set_flgs_o,
    output logic              busy_o
);

    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    typedef enum logic {IDLE, DATA} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        op_q, op_d;
    logic [31:0]       cmd_q, cmd_d;
    logic [STAGES-1:0] mask_q, mask_d, val_q, val_d, cfg_q, cfg_d;
    logic              arm_q, arm_d, swr_q, swr_d, id_q, id_d;
    logic              xon_q, xon_d, xoff_q, xoff_d;
    logic              div_q, div_d, scnt_q, scnt_d, flgs_q, flgs_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        op_d    = op_q;
        cmd_d   = cmd_q;
        mask_d  = '0;
        val_d   = '0;
        cfg_d   = '0;
        arm_d   = 1'b0;
        swr_d   = 1'b0;
        id_d    = 1'b0;
        xon_d   = 1'b0;
        xoff_d  = 1'b0;
        div_d   = 1'b0;
        scnt_d  = 1'b0;
        flgs_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (stb_i) begin
                    if (byte_i[7]) begin
                        op_d    = byte_i;
                        cnt_d   = 2'd0;
                        tmo_d   = '0;
                        state_d = DATA;
                    end else begin
                        case (byte_i)
                            8'h00:   swr_d  = 1'b1;
                            8'h01:   arm_d  = 1'b1;
                            8'h02:   id_d   = 1'b1;
                            8'h11:   xon_d  = 1'b1;
                            8'h13:   xoff_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            DATA: begin
                if (stb_i) begin
                    // A byte arriving in the expiry cycle still counts.
                    cmd_d[8*cnt_q +: 8] = byte_i;
                    cnt_d = cnt_q + 2'd1;
                    tmo_d = '0;
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                        case (op_q)
                            8'h80:   div_d  = 1'b1;
                            8'h81:   scnt_d = 1'b1;
                            8'h82:   flgs_d = 1'b1;
                            default: begin
                                if (op_q[7:4] == 4'hC) begin
                                    for (int s = 0; s < STAGES; s++) begin
                                        if (op_q[3:2] == 2'(s)) begin
                                            mask_d[s] = (op_q[1:0] == 2'd0);
                                            val_d[s]  = (op_q[1:0] == 2'd1);
                                            cfg_d[s]  = (op_q[1:0] == 2'd2);
                                        end
                                    end
                                end
                            end
                        endcase
                    end
                end else if (TMO > 0) begin
                    if (tmo_q == TW'(TMO - 1)) begin
                        state_d = IDLE;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            tmo_q   <= '0;
            op_q    <= 8'h00;
            cmd_q   <= 32'h0;
            mask_q  <= '0;
            val_q   <= '0;
            cfg_q   <= '0;
            arm_q   <= 1'b0;
            swr_q   <= 1'b0;
            id_q    <= 1'b0;
            xon_q   <= 1'b0;
            xoff_q  <= 1'b0;
            div_q   <= 1'b0;
            scnt_q  <= 1'b0;
            flgs_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            op_q    <= op_d;
            cmd_q   <= cmd_d;
            mask_q  <= mask_d;
            val_q   <= val_d;
            cfg_q   <= cfg_d;
            arm_q   <= arm_d;
            swr_q   <= swr_d;
            id_q    <= id_d;
            xon_q   <= xon_d;
            xoff_q  <= xoff_d;
            div_q   <= div_d;
            scnt_q  <= scnt_d;
            flgs_q  <= flgs_d;
        end
    end

    assign cmd_o      = cmd_q;
    assign set_mask_o = mask_q;
    assign set_val_o  = val_q;
    assign set_cfg_o  = cfg_q;
    assign arm_o      = arm_q;
    assign sw_rst_o   = swr_q;
    assign id_o       = id_q;
    assign xon_o      = xon_q;
    assign xoff_o     = xoff_q;
    assign set_div_o  = div_q;
    assign set_cnt_o  = scnt_q;
    assign set_flgs_o = flgs_q;
    assign busy_o     = (state_q == DATA);

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
Parameters:
REQ-001 STAGES, 4, number of trigger stages addressed; legal 1..4.
REQ-002 TMO, 65536, idle cycles after which a partial long command is discarded; 0 disables the timeout.
Ports:
REQ-003 clk_i  in  1  system clock; one clock, all logic on rising edge.
REQ-004 rst_in  in  1  reset, asynchronous, active-low.
REQ-005 byte_i  in  8  received byte from UART receiver.
REQ-006 stb_i  in  1  byte_i valid, one-cycle pulse per byte.
REQ-007 cmd_o  out  32  assembled long-command argument; first received data byte in [7:0], last in [31:24].
REQ-008 set_mask_o  out  STAGES  one-hot pulse, load trigger mask of stage n.
REQ-009 set_val_o  out  STAGES  one-hot pulse, load trigger value of stage n.
REQ-010 set_cfg_o  out  STAGES  one-hot pulse, load trigger configuration of stage n.
REQ-011 arm_o, sw_rst_o, id_o, xon_o, xoff_o  out  1 each  short-command pulses.
REQ-012 set_div_o, set_cnt_o, set_flgs_o  out  1 each  long-command pulses for divider, read/delay count, flags.
REQ-013 busy_o  out  1  high while a long command is partially received.

Function
REQ-014 The block SHALL implement FSM states IDLE, DATA; byte counter cnt (0..3) and timeout counter tmo_cnt.
REQ-015 IDLE, stb_i with byte_i[7]=0: short command; SHALL pulse exactly one strobe for one cycle, in the cycle after stb_i: 0x00 sw_rst_o, 0x01 arm_o, 0x02 id_o, 0x11 xon_o, 0x13 xoff_o; other values are ignored, with no pulse; state stays IDLE.
REQ-016 IDLE, stb_i with byte_i[7]=1: SHALL latch the opcode, clear cnt and tmo_cnt, and go to DATA; busy_o=1 from the next cycle.
REQ-017 DATA, each stb_i: SHALL store byte_i into cmd_o byte lane cnt, increment cnt, and clear tmo_cnt.
REQ-018 On the 4th data byte, the block SHALL return to IDLE and pulse the decoded strobe for one cycle in the cycle after that stb_i; cmd_o SHALL hold the full word in that cycle.
REQ-019 Decode: 0xC0-0xCF, stage n=opcode[3:2], function=opcode[1:0]: 0 mask, 1 val, 2 cfg, 3 ignored.
REQ-020 Decode: 0x80 set_div_o, 0x81 set_cnt_o, 0x82 set_flgs_o.
REQ-021 Unknown long opcodes, and stage n>=STAGES, SHALL consume 4 data bytes and produce no strobe.
REQ-022 In DATA, all byte values including 0x00 SHALL be treated as data, never as short commands.
REQ-023 cmd_o SHALL change only while bytes are stored and SHALL hold its value between commands.
REQ-024 At most one strobe output SHALL be high in any cycle.
REQ-025 Timeout: in DATA with TMO>0, tmo_cnt SHALL increment on each cycle without stb_i; when it reaches TMO, the block SHALL go to IDLE with no strobe and clear busy_o.
REQ-026 Timeout expiry and stb_i in the same cycle: the byte SHALL win; it is stored and tmo_cnt cleared.
REQ-027 Every stb_i byte SHALL be accepted; there is no backpressure, and stb_i on consecutive cycles is legal.

Reset
REQ-028 While rst_in=0, the block SHALL be in state IDLE, with cnt=0, tmo_cnt=0, cmd_o=0x00000000, all strobes 0, and busy_o=0.
REQ-029 Assertion of rst_in mid long command SHALL discard the partial command; no strobe is produced after release.
REQ-030 sw_rst_o is an output only and SHALL NOT reset this block's own state.

Verification
REQ-031 Reset: rst_in=0 asynchronously mid-cycle -> immediate cmd_o=0, busy_o=0, all strobes 0.
REQ-032 byte 0x01 -> arm_o=1 for exactly one cycle, one cycle after stb_i; no other strobe.
REQ-033 bytes 0xC0,0x78,0x56,0x34,0x12 -> cmd_o=0x12345678, set_mask_o=0001 one cycle after the 5th stb_i; busy_o=1 during bytes 2-5.
REQ-034 bytes 0xC6,0x00,0x00,0x00,0x08 back-to-back -> set_cfg_o=0010, cmd_o=0x08000000; the 0x00 data bytes cause no sw_rst_o.
REQ-035 TMO=16: 0xC1,0xAA,0xBB, then 16 idle cycles, then 0x02 -> no set_val_o, busy_o=0 after timeout, id_o pulse.
REQ-036 STAGES=2: 0xCC plus 4 bytes -> no strobe; a following 0x00 yields sw_rst_o.
